// File: rtl/reg_file_wr_ctrl.sv
// reg_file_wr_ctrl: owns the register file write port. Runs an init pass after reset, then
// arbitrates writeback against a debug write channel. Macro REGCTRL_INIT_ALL_EN: init all 32 regs.
module reg_file_wr_ctrl #(
    parameter logic [4:0]  SP_ADDR      = 5'd2,
    parameter logic [31:0] SP_INIT      = 32'h0000_1000,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        dbg_wr_valid,
    output logic        dbg_wr_ready,
    input  logic [4:0]  dbg_wr_addr,
    input  logic [31:0] dbg_wr_data,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_value,
    output logic        init_done,
    output logic        stall_req,
    output logic        wb_err
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [7:0] StarveMax = 8'(STARVE_LIMIT);
`ifdef REGCTRL_INIT_ALL_EN
    localparam logic [4:0] InitLast = 5'd31;
`else
    localparam logic [4:0] InitLast = 5'd1;
`endif

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gen_bad_limit
        $error("STARVE_LIMIT must be in 1..255");
    end

    state_e      state_q, state_d;
    logic [4:0]  init_ptr_q, init_ptr_d;
    logic [7:0]  starve_cnt_q, starve_cnt_d;
    logic        init_done_q, init_done_d;
    logic        stall_req_q, stall_req_d;
    logic        wb_err_q, wb_err_d;
    logic [4:0]  init_addr;
    logic        dbg_blocked;

    // Short init pass uses the pointer as a step index: step 0 -> x0, step 1 -> stack pointer.
`ifdef REGCTRL_INIT_ALL_EN
    assign init_addr = init_ptr_q;
`else
    assign init_addr = (init_ptr_q == 5'd0) ? 5'd0 : SP_ADDR;
`endif

    assign dbg_blocked = (state_q == StRun) && wb_en && dbg_wr_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= StInit;
            init_ptr_q   <= 5'd0;
            starve_cnt_q <= 8'd0;
            init_done_q  <= 1'b0;
            stall_req_q  <= 1'b1;
            wb_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            init_done_q  <= init_done_d;
            stall_req_q  <= stall_req_d;
            wb_err_q     <= wb_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        starve_cnt_d = starve_cnt_q;
        init_done_d  = init_done_q;
        stall_req_d  = stall_req_q;
        wb_err_d     = wb_err_q;
        unique case (state_q)
            StInit: begin
                init_ptr_d = init_ptr_q + 5'd1;
                if (wb_en) begin
                    wb_err_d = 1'b1;
                end
                if (init_ptr_q == InitLast) begin
                    state_d      = StRun;
                    init_ptr_d   = 5'd0;
                    starve_cnt_d = 8'd0;
                    init_done_d  = 1'b1;
                    stall_req_d  = 1'b0;
                end
            end
            StRun: begin
                // Not blocked means either no request or a completed transfer; both clear.
                if (dbg_blocked) begin
                    if (starve_cnt_q != StarveMax) begin
                        starve_cnt_d = starve_cnt_q + 8'd1;
                    end
                    if (starve_cnt_d == StarveMax) begin
                        stall_req_d = 1'b1;
                    end
                end else begin
                    starve_cnt_d = 8'd0;
                    stall_req_d  = 1'b0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    // Port mux; everything is held off while reset is asserted so no transfer can complete.
    always_comb begin
        rf_write_en    = 1'b0;
        rf_write_addr  = 5'd0;
        rf_write_value = 32'd0;
        dbg_wr_ready   = 1'b0;
        if (reset) begin
            unique case (state_q)
                StInit: begin
                    rf_write_en    = 1'b1;
                    rf_write_addr  = init_addr;
                    rf_write_value = (init_addr == SP_ADDR) ? SP_INIT : 32'd0;
                end
                StRun: begin
                    if (wb_en) begin
                        rf_write_en    = (wb_addr != 5'd0);
                        rf_write_addr  = wb_addr;
                        rf_write_value = wb_data;
                    end else begin
                        dbg_wr_ready = 1'b1;
                        if (dbg_wr_valid) begin
                            rf_write_en    = (dbg_wr_addr != 5'd0);
                            rf_write_addr  = dbg_wr_addr;
                            rf_write_value = dbg_wr_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign init_done = init_done_q;
    assign stall_req = stall_req_q;
    assign wb_err    = wb_err_q;

endmodule
